// File: rtl/auto_player_pkg.sv
// Shared types and default timing for the auto_player self-test responder.
package auto_player_pkg;

  localparam int unsigned DIG_W = 4;
  localparam int unsigned CNT_W = 16;

  localparam int unsigned DEF_DEPTH       = 8;
  localparam int unsigned DEF_RNG_LOW_CYC = 2;
  localparam int unsigned DEF_SETUP_CYC   = 4;
  localparam int unsigned DEF_THINK_CYC   = 20;
  localparam int unsigned DEF_RESULT_TMO  = 64;

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StCapture,
    StThink,
    StSet,
    StPunch,
    StResult,
    StEnd
  } state_e;

endpackage

// File: rtl/auto_seq_buf.sv
// Digit capture buffer: sequential write with a running count, random read port.
module auto_seq_buf
  import auto_player_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [DIG_W-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DIG_W-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [DIG_W-1:0] mem_q [DEPTH];
  logic [LW-1:0]    count_q;

  // Writes beyond DEPTH are dropped; the owner flags the overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (we_i && !full_o) begin
      mem_q[count_q[AW-1:0]] <= wdata_i;
      count_q                <= count_q + LW'(1);
    end
  end

  assign full_o  = (count_q == LW'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/auto_player.sv
// Automatic player for game_level: requests a round, captures the flashed digits, replays them.
// Optional AUTO_PLAYER_ERR_INJECT_EN adds err_en_i/err_idx_i to invert one replayed answer.
module auto_player
  import auto_player_pkg::*;
#(
  parameter int unsigned DEPTH       = DEF_DEPTH,
  parameter int unsigned RNG_LOW_CYC = DEF_RNG_LOW_CYC,
  parameter int unsigned SETUP_CYC   = DEF_SETUP_CYC,
  parameter int unsigned THINK_CYC   = DEF_THINK_CYC,
  parameter int unsigned RESULT_TMO  = DEF_RESULT_TMO
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     start_i,
  input  logic                     flash_valid_i,
  input  logic [DIG_W-1:0]         flash_num_i,
  input  logic                     flash_done_i,
  input  logic                     win_i,
  input  logic                     loose_i,
`ifdef AUTO_PLAYER_ERR_INJECT_EN
  input  logic                     err_en_i,
  input  logic [$clog2(DEPTH)-1:0] err_idx_i,
`endif
  output logic                     rng_button_o,
  output logic [DIG_W-1:0]         toggle_answer_o,
  output logic                     punch_button_o,
  output logic                     busy_o,
  output logic                     pass_o,
  output logic                     fail_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   seq_len_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [LW-1:0]    rd_ptr_q;
  logic             rng_q, punch_q, busy_q, pass_q, fail_q, ovf_q;
  logic [DIG_W-1:0] toggle_q;

  logic             buf_clr, buf_we, buf_full, ovf_hit, corrupt;
  logic [DIG_W-1:0] buf_rdata, answer;
  logic [LW-1:0]    buf_count, len_next;

  auto_seq_buf #(
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .wdata_i (flash_num_i),
    .raddr_i (rd_ptr_q[AW-1:0]),
    .rdata_o (buf_rdata),
    .count_o (buf_count),
    .full_o  (buf_full)
  );

  always_comb begin
    buf_clr  = (state_q == StIdle) && start_i;
    buf_we   = (state_q == StCapture) && flash_valid_i;
    ovf_hit  = buf_we && buf_full;
    // Length including a digit written in the same cycle as flash_done.
    len_next = buf_count + LW'(buf_we && !buf_full);
`ifdef AUTO_PLAYER_ERR_INJECT_EN
    corrupt  = err_en_i && (rd_ptr_q == {1'b0, err_idx_i});
`else
    corrupt  = 1'b0;
`endif
    answer   = buf_rdata ^ {DIG_W{corrupt}};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      rng_q    <= 1'b1;
      toggle_q <= '0;
      punch_q  <= 1'b0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      punch_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            rng_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (cnt_q == CNT_W'(RNG_LOW_CYC - 1)) begin
            rng_q   <= 1'b1;
            state_q <= StCapture;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StCapture: begin
          if (ovf_hit) begin
            ovf_q  <= 1'b1;
            fail_q <= 1'b1;
          end
          if (flash_done_i) begin
            if (ovf_q || ovf_hit) begin
              state_q <= StEnd;
            end else if (len_next == '0) begin
              fail_q  <= 1'b1;
              state_q <= StEnd;
            end else begin
              cnt_q    <= '0;
              rd_ptr_q <= '0;
              state_q  <= StThink;
            end
          end
        end
        StThink: begin
          if (cnt_q == CNT_W'(THINK_CYC - 1)) begin
            toggle_q <= answer;
            cnt_q    <= '0;
            state_q  <= StSet;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StSet: begin
          if (loose_i) begin
            fail_q  <= 1'b1;
            state_q <= StEnd;
          end else if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
            punch_q  <= 1'b1;
            rd_ptr_q <= rd_ptr_q + LW'(1);
            state_q  <= StPunch;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StPunch: begin
          // rd_ptr already points at the next digit, so the next SET loads it here.
          if (loose_i) begin
            fail_q  <= 1'b1;
            state_q <= StEnd;
          end else if (rd_ptr_q == buf_count) begin
            cnt_q   <= '0;
            state_q <= StResult;
          end else begin
            toggle_q <= answer;
            cnt_q    <= '0;
            state_q  <= StSet;
          end
        end
        StResult: begin
          if (loose_i) begin
            fail_q  <= 1'b1;
            state_q <= StEnd;
          end else if (win_i) begin
            pass_q  <= 1'b1;
            state_q <= StEnd;
          end else if (cnt_q == CNT_W'(RESULT_TMO - 1)) begin
            fail_q  <= 1'b1;
            state_q <= StEnd;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        StEnd: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rng_button_o    = rng_q;
  assign toggle_answer_o = toggle_q;
  assign punch_button_o  = punch_q;
  assign busy_o          = busy_q;
  assign pass_o          = pass_q;
  assign fail_o          = fail_q;
  assign overflow_o      = ovf_q;
  assign seq_len_o       = buf_count;

endmodule

// File: tb/tb_auto_player.sv
// Directed bench for auto_player with a timeline model of request and replay outputs.
module tb_auto_player;

  localparam int DEPTH = 8;
  localparam int RNG   = 2;
  localparam int SETUP = 4;
  localparam int THINK = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, fv = 1'b0, fd = 1'b0, win = 1'b0, loose = 1'b0;
  logic [3:0] fnum = '0;
  logic       err_en = 1'b0;
  logic [2:0] err_idx = '0;
  logic       rng_button, punch, busy, pass, fail, ovf;
  logic [3:0] toggle;
  logic [3:0] seq_len;

  auto_player dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .flash_valid_i   (fv),
    .flash_num_i     (fnum),
    .flash_done_i    (fd),
    .win_i           (win),
    .loose_i         (loose),
`ifdef AUTO_PLAYER_ERR_INJECT_EN
    .err_en_i        (err_en),
    .err_idx_i       (err_idx),
`endif
    .rng_button_o    (rng_button),
    .toggle_answer_o (toggle),
    .punch_button_o  (punch),
    .busy_o          (busy),
    .pass_o          (pass),
    .fail_o          (fail),
    .overflow_o      (ovf),
    .seq_len_o       (seq_len)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0, bad = 0;

  // Model: request window after start, replay schedule after flash_done.
  bit         chk_en = 1'b0, m_rng_on = 1'b0, m_rep_on = 1'b0, m_err = 1'b0;
  int         t_s = 0, t_fd = 0, m_np = 0, m_err_k = 0, pulses = 0;
  logic [3:0] m_dig[$];
  int         md, mk;
  logic       ep, er;
  logic [3:0] et;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      er = !(m_rng_on && cyc >= t_s && cyc < t_s + RNG);
      chk("rng_button", 32'(rng_button), 32'(er));
      ep = 1'b0;
      if (m_rep_on && cyc >= t_fd + THINK) begin
        md = cyc - t_fd - THINK;
        mk = md / (SETUP + 1);
        if (mk < m_np) begin
          ep = (md % (SETUP + 1)) == SETUP;
          et = m_dig[mk];
          if (m_err && mk == m_err_k) et = ~et;
          chk("toggle_answer", 32'(toggle), 32'(et));
        end
      end
      chk("punch_button", 32'(punch), 32'(ep));
      if (punch) pulses++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic begin_round();
    m_dig.delete();
    m_rep_on = 1'b0;
    pulses   = 0;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    t_s      = cyc;
    m_rng_on = 1'b1;
    repeat (3) tick();
  endtask

  task automatic flash(input logic [3:0] d, input bit done);
    fnum = d;
    fv   = 1'b1;
    fd   = done;
    tick();
    fv = 1'b0;
    fd = 1'b0;
    if (m_dig.size() < DEPTH) m_dig.push_back(d);
    if (done) begin
      t_fd     = cyc;
      m_np     = m_dig.size();
      m_rep_on = 1'b1;
    end
    tick();
  endtask

  task automatic flash_done_only(input bit replay);
    fd = 1'b1;
    tick();
    fd       = 1'b0;
    t_fd     = cyc;
    m_np     = replay ? m_dig.size() : 0;
    m_rep_on = replay;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_rng"}, 32'(rng_button), 32'd1);
    chk({tag, "_toggle"}, 32'(toggle), 32'd0);
    chk({tag, "_punch"}, 32'(punch), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_pass"}, 32'(pass), 32'd0);
    chk({tag, "_fail"}, 32'(fail), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    chk({tag, "_seq_len"}, 32'(seq_len), 32'd0);
  endtask

  initial begin
    repeat (2) tick();
    check_reset_outputs("reset");
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Level-1 replay ending in win.
    begin_round();
    flash(4'd3, 0); flash(4'd13, 0); flash(4'd4, 0);
    flash_done_only(1);
    wait_until(t_fd + 24);
    chk("l1_first_answer", 32'(toggle), 32'b0011);
    chk("l1_first_punch", 32'(punch), 32'd1);
    wait_until(t_fd + 36);
    win = 1'b1; tick(); win = 1'b0;
    repeat (3) tick();
    chk("l1_pass", 32'(pass), 32'd1);
    chk("l1_fail", 32'(fail), 32'd0);
    chk("l1_busy", 32'(busy), 32'd0);
    chk("l1_seq_len", 32'(seq_len), 32'd3);
    chk("l1_pulses", 32'(pulses), 32'd3);

    // Level-5 length, stray start while busy, loose verdict.
    begin_round();
    flash(4'd7, 0); flash(4'd14, 0); flash(4'd4, 0); flash(4'd5, 0);
    flash(4'd8, 0); flash(4'd13, 0); flash(4'd5, 0);
    flash_done_only(1);
    wait_until(t_fd + 3);
    start = 1'b1; tick(); start = 1'b0;
    wait_until(t_fd + 29);
    chk("l5_second_answer", 32'(toggle), 32'd14);
    wait_until(t_fd + 56);
    loose = 1'b1; tick(); loose = 1'b0;
    repeat (3) tick();
    chk("l5_fail", 32'(fail), 32'd1);
    chk("l5_pass", 32'(pass), 32'd0);
    chk("l5_busy", 32'(busy), 32'd0);
    chk("l5_seq_len", 32'(seq_len), 32'd7);
    chk("l5_pulses", 32'(pulses), 32'd7);

    // Overflow: nine strobes, no replay.
    begin_round();
    for (int i = 1; i <= 9; i++) flash(4'(i), 0);
    chk("ovf_before_done", 32'(ovf), 32'd1);
    flash_done_only(0);
    wait_until(t_fd + 40);
    chk("ovf_flag", 32'(ovf), 32'd1);
    chk("ovf_fail", 32'(fail), 32'd1);
    chk("ovf_seq_len", 32'(seq_len), 32'd8);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_pulses", 32'(pulses), 32'd0);

    // Empty round.
    begin_round();
    flash_done_only(0);
    repeat (3) tick();
    chk("empty_fail", 32'(fail), 32'd1);
    chk("empty_ovf", 32'(ovf), 32'd0);
    chk("empty_seq_len", 32'(seq_len), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);

    // Timeout, with last digit and flash_done in the same cycle.
    begin_round();
    flash(4'd9, 0); flash(4'd2, 0); flash(4'd6, 1);
    wait_until(t_fd + 98);
    chk("tmo_fail_early", 32'(fail), 32'd0);
    chk("tmo_busy_early", 32'(busy), 32'd1);
    wait_until(t_fd + 100);
    chk("tmo_fail", 32'(fail), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    chk("tmo_seq_len", 32'(seq_len), 32'd3);
    chk("tmo_pulses", 32'(pulses), 32'd3);

    // Reset during the second setup window, then a fresh round.
    begin_round();
    flash(4'd5, 0); flash(4'd10, 0); flash(4'd15, 0);
    flash_done_only(1);
    wait_until(t_fd + 26);
    chk("rst_in_second_setup", 32'(toggle), 32'd10);
    chk_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset_outputs("midrst");
    m_rep_on = 1'b0;
    m_rng_on = 1'b0;
    pulses   = 0;
    repeat (2) tick();
    rst_n  = 1'b1;
    chk_en = 1'b1;
    repeat (3) tick();
    chk("post_rst_pulses", 32'(pulses), 32'd0);
    begin_round();
    flash(4'd9, 0); flash(4'd2, 0);
    flash_done_only(1);
    wait_until(t_fd + 31);
    win = 1'b1; tick(); win = 1'b0;
    repeat (3) tick();
    chk("post_rst_pass", 32'(pass), 32'd1);
    chk("post_rst_pulses2", 32'(pulses), 32'd2);

`ifdef AUTO_PLAYER_ERR_INJECT_EN
    // Second answer inverted; loose cuts the replay short.
    err_en  = 1'b1;
    err_idx = 3'd1;
    m_err   = 1'b1;
    m_err_k = 1;
    begin_round();
    flash(4'd4, 0); flash(4'd8, 0); flash(4'd5, 0); flash(4'd7, 0);
    flash_done_only(1);
    m_np = 2;
    wait_until(t_fd + 29);
    chk("err_answer", 32'(toggle), 32'b0111);
    chk("err_punch", 32'(punch), 32'd1);
    loose = 1'b1; tick(); loose = 1'b0;
    wait_until(t_fd + 45);
    chk("err_fail", 32'(fail), 32'd1);
    chk("err_busy", 32'(busy), 32'd0);
    chk("err_pulses", 32'(pulses), 32'd2);
    err_en = 1'b0;
    m_err  = 1'b0;
`endif

    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
